voltage_pwm: RTL and testbench

Downstream consumer of the Pi SPI slave's received byte `q`, running in the FPGA system clock domain. Watches the raw Pi SCLK to detect completed 8-bit frames and captures each finished byte. Drives the byte as the duty cycle of a glitch-free 8-bit PWM output that feeds the external RC filter acting as the analog voltage output.

---
 rtl/voltage_pwm_pkg.sv | 12 +
 rtl/voltage_pwm_if.sv | 21 ++
 rtl/voltage_pwm_pwm_gen.sv | 65 ++++++
 rtl/voltage_pwm.sv | 107 ++++++++++
 tb/tb_voltage_pwm.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/voltage_pwm_pkg.sv
// Shared types and default constants for the voltage PWM block.
package voltage_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} frame_state_t;

  localparam int BYTE_W = 8;

  localparam int DEF_PRESCALE = 4;
  localparam int DEF_IDLE_TIMEOUT = 1024;
  localparam logic [BYTE_W-1:0] DEF_RESET_DUTY = 8'h00;

endpackage

// File: rtl/voltage_pwm_if.sv
// Signal bundle between the SPI-side byte source and the voltage PWM block.
interface voltage_pwm_if;

  logic                          sclk_in;
  logic [voltage_pkg::BYTE_W-1:0] q;
  logic [voltage_pkg::BYTE_W-1:0] byte_out;
  logic                          frame_valid;
  logic [voltage_pkg::BYTE_W-1:0] duty;
  logic                          pwm_out;

  modport master (
    output sclk_in, q,
    input  byte_out, frame_valid, duty, pwm_out
  );

  modport slave (
    input  sclk_in, q,
    output byte_out, frame_valid, duty, pwm_out
  );

endinterface

// File: rtl/voltage_pwm_pwm_gen.sv
// 8-bit PWM with prescaler and a duty double-buffer that only swaps at the
// 255->0 wrap, so a period is never cut short or stretched.
module pwm_gen
  import voltage_pkg::*;
#(
  parameter int                PRESCALE   = DEF_PRESCALE,
  parameter logic [BYTE_W-1:0] RESET_DUTY = DEF_RESET_DUTY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] pending,
  input  logic              load_pending,
  output logic [BYTE_W-1:0] duty,
  output logic              pwm_out
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]   presc;
  logic [BYTE_W-1:0] pwm_cnt;
  logic [BYTE_W-1:0] pend_reg;
  logic              pend_flag;
  logic              tick;
  logic              wrap;

  assign tick = (presc == PS_LAST);
  assign wrap = tick && (pwm_cnt == '1);

  // Prescaler: one tick every PRESCALE clocks.
  always_ff @(posedge clk) begin
    if (!reset)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // PWM counter advances once per tick and wraps naturally at 255.
  always_ff @(posedge clk) begin
    if (!reset)    pwm_cnt <= '0;
    else if (tick) pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Duty buffer: a capture landing on the wrap bypasses straight to duty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      duty      <= RESET_DUTY;
      pend_reg  <= '0;
      pend_flag <= 1'b0;
    end else if (wrap) begin
      if (load_pending)   duty <= pending;
      else if (pend_flag) duty <= pend_reg;
      pend_flag <= 1'b0;
    end else if (load_pending) begin
      pend_reg  <= pending;
      pend_flag <= 1'b1;
    end
  end

  // Registered compare keeps the output glitch-free.
  always_ff @(posedge clk) begin
    if (!reset) pwm_out <= 1'b0;
    else        pwm_out <= (pwm_cnt < duty);
  end

endmodule

// File: rtl/voltage_pwm.sv
// Frames bytes from the Pi SPI slave by watching raw SCLK and feeds each
// captured byte to the PWM that drives the RC-filtered voltage output.
module voltage_pwm
  import voltage_pkg::*;
#(
  parameter int                PRESCALE     = DEF_PRESCALE,
  parameter int                IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
  parameter logic [BYTE_W-1:0] RESET_DUTY   = DEF_RESET_DUTY
) (
  input  logic          clk,
  input  logic          reset,
  voltage_pwm_if.slave  bus
);

  localparam int                IDLE_W   = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

  logic              s1, s2, s3;
  logic              rise, fall;
  frame_state_t      state, state_next;
  logic [3:0]        bit_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              capture;
  logic              timeout;
  logic [BYTE_W-1:0] byte_q;
  logic              frame_valid_c;

  // Two-flop synchronizer plus a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.sclk_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign capture = (state == SHIFT) && fall && (bit_cnt == 4'd8);
  assign timeout = (state == SHIFT) && (idle_cnt == IDLE_MAX);

  // Frame state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Frame next-state: a stalled partial frame falls back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rise) state_next = SHIFT;
      SHIFT: begin
        if (capture)      state_next = DONE;
        else if (timeout) state_next = IDLE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame outputs: the pulse is simply the one cycle spent in DONE.
  always_comb begin
    frame_valid_c = (state == DONE);
  end

  // Rising-edge count within a frame, saturating at a full byte.
  always_ff @(posedge clk) begin
    if (!reset)                      bit_cnt <= '0;
    else if (state_next != SHIFT)    bit_cnt <= '0;
    else if (state == IDLE)          bit_cnt <= 4'd1;
    else if (rise && bit_cnt != 4'd8) bit_cnt <= bit_cnt + 1'b1;
  end

  // Idle counter measures SCLK silence while a frame is open.
  always_ff @(posedge clk) begin
    if (!reset)                               idle_cnt <= '0;
    else if (state != SHIFT || rise || fall)  idle_cnt <= '0;
    else if (idle_cnt != IDLE_MAX)            idle_cnt <= idle_cnt + 1'b1;
  end

  // Capture the finished byte on the closing falling edge.
  always_ff @(posedge clk) begin
    if (!reset)       byte_q <= '0;
    else if (capture) byte_q <= bus.q;
  end

  assign bus.byte_out    = byte_q;
  assign bus.frame_valid = frame_valid_c;

  pwm_gen #(
    .PRESCALE   (PRESCALE),
    .RESET_DUTY (RESET_DUTY)
  ) u_pwm (
    .clk          (clk),
    .reset        (reset),
    .pending      (bus.q),
    .load_pending (capture),
    .duty         (bus.duty),
    .pwm_out      (bus.pwm_out)
  );

endmodule

// File: tb/tb_voltage_pwm.sv
// Directed bench for voltage_pwm with a cycle-level arithmetic model.
module tb_voltage_pwm;
  import voltage_pkg::*;

  localparam int P      = 4;
  localparam int PERIOD = 256 * P;

  logic clk = 1'b0;
  logic reset;

  voltage_pwm_if bus();

  voltage_pwm #(
    .PRESCALE     (P),
    .IDLE_TIMEOUT (1024),
    .RESET_DUTY   (8'h00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int compareCount  = 0;
  int mismatchCount = 0;
  int fvPulses      = 0;
  bit checkEnable   = 1'b0;

  // Scheduling info written by the stimulus, read by the model.
  int         edgeCount      = 0;
  int         expCaptureEdge = -1;
  logic [7:0] expByte        = 8'h00;

  // Model state: phase since reset plus the duty/pending/byte bookkeeping.
  int         modelK    = 0;
  logic [7:0] mDuty     = 8'h00;
  logic [7:0] mPend     = 8'h00;
  logic [7:0] mByte     = 8'h00;
  logic       mPendFlag = 1'b0;
  logic       mFv       = 1'b0;
  logic       mPwm      = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Model: PWM count is floor(k/P) mod 256, duty swaps whenever k hits a period boundary.
  always @(posedge clk) begin
    int         kNext;
    logic       cap;
    logic [7:0] dNext;
    logic [7:0] pNext;
    logic       pfNext;
    edgeCount <= edgeCount + 1;
    if (reset !== 1'b1) begin
      modelK    <= 0;
      mDuty     <= 8'h00;
      mPend     <= 8'h00;
      mPendFlag <= 1'b0;
      mByte     <= 8'h00;
      mFv       <= 1'b0;
      mPwm      <= 1'b0;
    end else begin
      kNext  = modelK + 1;
      cap    = (edgeCount + 1 == expCaptureEdge);
      dNext  = mDuty;
      pNext  = mPend;
      pfNext = mPendFlag;
      if (kNext % PERIOD == 0) begin
        if (cap)            dNext = expByte;
        else if (mPendFlag) dNext = mPend;
        pfNext = 1'b0;
      end else if (cap) begin
        pNext  = expByte;
        pfNext = 1'b1;
      end
      mPwm      <= (((modelK / P) % 256) < int'(mDuty));
      modelK    <= kNext;
      mDuty     <= dNext;
      mPend     <= pNext;
      mPendFlag <= pfNext;
      mFv       <= cap;
      if (cap) mByte <= expByte;
    end
  end

  // Compare every cycle once reset has been seen.
  always @(negedge clk) begin
    if (checkEnable) begin
      checkOutput("frame_valid", {31'b0, bus.frame_valid}, {31'b0, mFv});
      checkOutput("byte_out",    {24'b0, bus.byte_out},    {24'b0, mByte});
      checkOutput("duty",        {24'b0, bus.duty},        {24'b0, mDuty});
      checkOutput("pwm_out",     {31'b0, bus.pwm_out},     {31'b0, mPwm});
      if (bus.frame_valid === 1'b1) fvPulses++;
    end
  end

  // Drive nBits SCLK periods (8 high, 8 low); a full byte schedules a capture.
  task automatic applyStimulus(input int nBits, input logic [7:0] value);
    bus.q = ~value;
    for (int i = 0; i < nBits; i++) begin
      bus.sclk_in = 1'b1;
      if (i == 7) bus.q = value;
      repeat (8) @(negedge clk);
      bus.sclk_in = 1'b0;
      if (i == 7) begin
        expByte        = value;
        expCaptureEdge = edgeCount + 3;
      end
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic waitPhase(input string name, input int target);
    bit seen = 1'b0;
    for (int i = 0; i < PERIOD + 16 && !seen; i++) begin
      @(negedge clk);
      if (modelK % PERIOD == target) seen = 1'b1;
    end
    if (!seen) checkOutput(name, 32'd0, 32'd1);
  endtask

  task automatic countHigh(output int highs);
    highs = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      if (bus.pwm_out === 1'b1) highs++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int h;
    reset       = 1'b0;
    bus.sclk_in = 1'b0;
    bus.q       = 8'h00;

    @(negedge clk);
    checkEnable = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_pwm_out", {31'b0, bus.pwm_out}, 32'd0);
    checkOutput("rst_duty", {24'b0, bus.duty}, 32'h00);
    checkOutput("rst_byte_out", {24'b0, bus.byte_out}, 32'h00);
    checkOutput("rst_frame_valid", {31'b0, bus.frame_valid}, 32'd0);
    checkOutput("rst_pwm_cnt", {24'b0, dut.u_pwm.pwm_cnt}, 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] full frame A5");
    applyStimulus(8, 8'hA5);
    checkOutput("byte_A5", {24'b0, bus.byte_out}, 32'hA5);
    checkOutput("pulses_A5", fvPulses, 32'd1);
    waitPhase("wrap_A5", 0);
    checkOutput("duty_A5", {24'b0, bus.duty}, 32'hA5);
    countHigh(h);
    checkOutput("highs_A5", h, 165 * P);

    $display("[TB] partial frame then 3C");
    applyStimulus(5, 8'hEE);
    repeat (1100) @(negedge clk);
    checkOutput("pulses_partial", fvPulses, 32'd1);
    applyStimulus(8, 8'h3C);
    checkOutput("byte_3C", {24'b0, bus.byte_out}, 32'h3C);
    checkOutput("pulses_3C", fvPulses, 32'd2);

    $display("[TB] mid-period update C0 -> 40");
    applyStimulus(8, 8'hC0);
    waitPhase("wrap_C0", 0);
    checkOutput("duty_C0", {24'b0, bus.duty}, 32'hC0);
    waitPhase("phase_941", 941);
    applyStimulus(8, 8'h40);
    checkOutput("duty_hold_C0", {24'b0, bus.duty}, 32'hC0);
    waitPhase("wrap_40", 0);
    checkOutput("duty_40", {24'b0, bus.duty}, 32'h40);

    $display("[TB] duty 00");
    applyStimulus(8, 8'h00);
    waitPhase("wrap_00", 0);
    checkOutput("duty_00", {24'b0, bus.duty}, 32'h00);
    countHigh(h);
    checkOutput("highs_00", h, 32'd0);

    $display("[TB] duty FF");
    applyStimulus(8, 8'hFF);
    waitPhase("wrap_FF", 0);
    checkOutput("duty_FF", {24'b0, bus.duty}, 32'hFF);
    countHigh(h);
    checkOutput("lows_FF", PERIOD - h, P);

    $display("[TB] capture on the wrap");
    waitPhase("phase_901", PERIOD - 123);
    applyStimulus(8, 8'h5A);
    checkOutput("duty_bypass_5A", {24'b0, bus.duty}, 32'h5A);
    checkOutput("pulses_5A", fvPulses, 32'd7);

    $display("[TB] reset mid-frame");
    applyStimulus(2, 8'h99);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrst_byte_out", {24'b0, bus.byte_out}, 32'h00);
    checkOutput("midrst_pwm_cnt", {24'b0, dut.u_pwm.pwm_cnt}, 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("pulses_midrst", fvPulses, 32'd7);
    applyStimulus(8, 8'h77);
    checkOutput("byte_77", {24'b0, bus.byte_out}, 32'h77);
    checkOutput("pulses_77", fvPulses, 32'd8);
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
